// File: rtl/siso_loopback_arbiter.sv
// Two-requester round-robin front end for a shared SISO delay chain: each granted word is
// sent MSB-first into the chain, recaptured DEPTH cycles later and returned with its ID.
module siso_loopback_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             ser_in,
    input  logic             ser_out,
    output logic [WIDTH-1:0] dout,
    output logic             done,
    output logic             done_id
);
    localparam int LAST = WIDTH + DEPTH - 1;
    localparam int CW   = $clog2(LAST + 1);
    localparam int SW   = (WIDTH > 1) ? WIDTH - 1 : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [SW-1:0]    r_shift;
    logic [WIDTH-1:0] r_rx;
    logic [WIDTH-1:0] r_dout;
    logic             r_ser_in;
    logic             r_id;
    logic             r_done_id;
    logic             r_prio;
    logic [1:0]       w_pick;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] w_rx_next;
    logic [SW-1:0]    w_rest;
    logic             w_last;
    logic             w_capture;

    assign w_word    = w_pick[1] ? din1 : din0;
    assign w_last    = (r_cnt == CW'(LAST));
    assign w_capture = (r_cnt >= CW'(DEPTH));

    // The last captured bit arrives on the same edge that loads dout, so both use w_rx_next.
    generate
        if (WIDTH > 1) begin : g_wide
            assign w_rest    = w_word[WIDTH-2:0];
            assign w_rx_next = {r_rx[WIDTH-2:0], ser_out};
        end else begin : g_narrow
            assign w_rest    = 1'b0;
            assign w_rx_next = ser_out;
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_pick       = 2'b00;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req == 2'b11) begin
                    w_pick = r_prio ? 2'b10 : 2'b01;
                end else begin
                    w_pick = req;
                end
                if (|req) begin
                    w_state_next = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Grant is combinational, so it is masked while reset is held.
    assign gnt     = reset ? w_pick : 2'b00;
    assign ser_in  = r_ser_in;
    assign dout    = r_dout;
    assign done_id = r_done_id;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_shift   <= '0;
            r_rx      <= '0;
            r_dout    <= '0;
            r_ser_in  <= 1'b0;
            r_id      <= 1'b0;
            r_done_id <= 1'b0;
            r_prio    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_id     <= w_pick[1];
                        r_ser_in <= w_word[WIDTH-1];
                        r_shift  <= w_rest;
                        r_cnt    <= '0;
                    end
                end
                S_ACTIVE: begin
                    // Zero-filled shift drives ser_in low once the word is exhausted.
                    r_cnt    <= r_cnt + 1'b1;
                    r_ser_in <= r_shift[SW-1];
                    r_shift  <= r_shift << 1;
                    if (w_capture) begin
                        r_rx <= w_rx_next;
                    end
                    if (w_last) begin
                        r_cnt     <= '0;
                        r_ser_in  <= 1'b0;
                        r_dout    <= w_rx_next;
                        r_done_id <= r_id;
                        r_prio    <= ~r_id;
                    end
                end
                default: r_ser_in <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_siso_loopback_arbiter.sv
// Bench for siso_loopback_arbiter: models the SISO chain, predicts grants round-robin from
// the request levels and checks every recovered word, tag, serial stream and latency.
module tb_siso_loopback_arbiter;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int L  = W + D;
    localparam int WS = 4;
    localparam int DS = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req, gnt;
    logic [W-1:0]  din0, din1, dout;
    logic          busy, ser_in, ser_out, done, done_id;
    logic [D-1:0]  chain;
    logic [1:0]    req_s, gnt_s;
    logic [WS-1:0] din0_s, din1_s, dout_s;
    logic          busy_s, ser_in_s, ser_out_s, done_s, done_id_s;
    logic          chain_s;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int model_last = 1;

    siso_loopback_arbiter #(.WIDTH(W), .DEPTH(D)) u_dut (
        .clk(clk), .reset(reset), .req(req), .din0(din0), .din1(din1), .gnt(gnt),
        .busy(busy), .ser_in(ser_in), .ser_out(ser_out), .dout(dout), .done(done),
        .done_id(done_id)
    );

    siso_loopback_arbiter #(.WIDTH(WS), .DEPTH(DS)) u_dut_s (
        .clk(clk), .reset(reset), .req(req_s), .din0(din0_s), .din1(din1_s), .gnt(gnt_s),
        .busy(busy_s), .ser_in(ser_in_s), .ser_out(ser_out_s), .dout(dout_s), .done(done_s),
        .done_id(done_id_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset) begin
        if (!reset) chain <= '0;
        else        chain <= {chain[D-2:0], ser_in};
    end
    assign ser_out = chain[D-1];

    always @(posedge clk or negedge reset) begin
        if (!reset) chain_s <= 1'b0;
        else        chain_s <= ser_in_s;
    end
    assign ser_out_s = chain_s;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Round-robin reference: a lone request wins; on a tie the one not served last wins.
    function automatic int pick(input logic [1:0] r);
        if (r == 2'b11) return (model_last == 0) ? 1 : 0;
        return r[1] ? 1 : 0;
    endfunction

    // Observes one transfer on the main DUT (no comparisons here): waits for a grant,
    // records the serial stream over ACTIVE and the completion it produces.
    task automatic observe(input bit drop, input int inj_c, input logic [1:0] inj,
                           output bit ok, output logic [1:0] g, output int gc,
                           output logic [L-1:0] sq, output int dc, output logic [W-1:0] dv,
                           output logic di, output bit stray);
        ok = 1'b0; stray = 1'b0; g = '0; gc = 0; sq = '0; dc = 0; dv = '0; di = 1'b0;
        for (int k = 0; k < 4 * L; k++) begin
            #1;
            if (gnt != 2'b00) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) return;
        g = gnt; gc = cyc;
        for (int c = 0; c < L; c++) begin
            @(negedge clk);
            if (c == 0 && drop) req = req & ~g;
            if (c == inj_c) req = req | inj;
            #1;
            sq[L-1-c] = ser_in;
            if (gnt != 2'b00 || done || !busy) stray = 1'b1;
        end
        ok = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            if (done) begin ok = 1'b1; break; end
        end
        dc = cyc; dv = dout; di = done_id;
        if (gnt != 2'b00 || !busy) stray = 1'b1;
        $display("[TB] xfer gnt=%b at %0d done at %0d id=%0d dout=%h", g, gc, dc, di, dv);
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 2'b11; din0 = 8'h5A; din1 = 8'hA5;
        req_s = 2'b11; din0_s = 4'h6; din1_s = 4'h9;
        #1;
        n_tests++;
        if ({gnt, busy, ser_in, done, done_id, dout} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", {gnt, busy, ser_in, done, done_id, dout});
        end
        n_tests++;
        if ({gnt_s, busy_s, ser_in_s, done_s, done_id_s, dout_s} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_small: got %h want 0",
                     {gnt_s, busy_s, ser_in_s, done_s, done_id_s, dout_s});
        end
        repeat (3) @(negedge clk);
        req = 2'b00; req_s = 2'b00;
        reset = 1'b1;
        model_last = 1;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit ok, stray; logic [1:0] g; int gc, dc; logic [L-1:0] sq; logic [W-1:0] dv; logic di;
        din0 = 8'hA5; req = 2'b01;
        observe(1'b1, -1, 2'b00, ok, g, gc, sq, dc, dv, di, stray);
        n_tests++;
        if (!ok || g !== 2'b01) begin
            n_fail++; $display("FAIL single_gnt: got %b ok=%0d want 01", g, ok);
        end
        n_tests++;
        if (sq !== {8'hA5, 4'h0}) begin
            n_fail++; $display("FAIL single_ser_in: got %b want %b", sq, {8'hA5, 4'h0});
        end
        n_tests++;
        if (dc - gc != L + 1) begin
            n_fail++; $display("FAIL single_latency: got %0d want %0d", dc - gc, L + 1);
        end
        n_tests++;
        if (dv !== 8'hA5 || di !== 1'b0 || stray) begin
            n_fail++; $display("FAIL single_result: got dout=%h id=%b stray=%0d want a5/0/0", dv, di, stray);
        end
        model_last = 0;
        @(negedge clk); #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || dout !== 8'hA5) begin
            n_fail++; $display("FAIL single_after: got busy=%b done=%b dout=%h want 0/0/a5", busy, done, dout);
        end
    endtask

    task automatic test_back_to_back();
        bit ok, stray; logic [1:0] g; int gc, dc, prev, exp_id; logic [L-1:0] sq;
        logic [W-1:0] dv, exp_w; logic di;
        din0 = 8'h3C; din1 = 8'hC3; req = 2'b11; prev = 0;
        for (int k = 0; k < 4; k++) begin
            exp_id = pick(req);
            exp_w  = (exp_id == 1) ? din1 : din0;
            observe(1'b0, -1, 2'b00, ok, g, gc, sq, dc, dv, di, stray);
            n_tests++;
            if (!ok || g !== ((exp_id == 1) ? 2'b10 : 2'b01) || stray) begin
                n_fail++; $display("FAIL b2b_gnt[%0d]: got %b stray=%0d want id %0d", k, g, stray, exp_id);
            end
            n_tests++;
            if (dv !== exp_w || di !== 1'(exp_id)) begin
                n_fail++; $display("FAIL b2b_result[%0d]: got %h/%b want %h/%0d", k, dv, di, exp_w, exp_id);
            end
            if (k > 0) begin
                n_tests++;
                if (gc - prev != L + 2) begin
                    n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", k, gc - prev, L + 2);
                end
            end
            prev = gc;
            model_last = exp_id;
        end
        req = 2'b00;
    endtask

    task automatic test_req_during_busy();
        bit ok, stray; logic [1:0] g; int gc, dc, d0; logic [L-1:0] sq;
        logic [W-1:0] dv, w0, w1; logic di;
        w0 = W'($urandom); w1 = W'($urandom);
        din0 = w0; din1 = w1; req = 2'b01;
        observe(1'b1, 3, 2'b10, ok, g, gc, sq, dc, dv, di, stray);
        n_tests++;
        if (!ok || g !== 2'b01 || stray) begin
            n_fail++; $display("FAIL busy_first: got gnt=%b stray=%0d want 01/0", g, stray);
        end
        n_tests++;
        if (dv !== w0 || di !== 1'b0 || sq !== {w0, 4'h0}) begin
            n_fail++; $display("FAIL busy_first_result: got %h/%b want %h/0", dv, di, w0);
        end
        model_last = 0; d0 = dc;
        observe(1'b1, -1, 2'b00, ok, g, gc, sq, dc, dv, di, stray);
        n_tests++;
        if (!ok || g !== 2'b10 || gc - d0 != 1) begin
            n_fail++; $display("FAIL busy_second_gnt: got %b after %0d cycles want 10 after 1", g, gc - d0);
        end
        n_tests++;
        if (dv !== w1 || di !== 1'b1) begin
            n_fail++; $display("FAIL busy_second_result: got %h/%b want %h/1", dv, di, w1);
        end
        model_last = 1;
    endtask

    task automatic test_reset_mid();
        bit ok, seen, stray; logic [1:0] g; int gc, dc; logic [L-1:0] sq;
        logic [W-1:0] dv, w0, w1; logic di;
        w0 = W'($urandom); w1 = W'($urandom);
        din0 = w0; din1 = w1; req = 2'b01; ok = 1'b0;
        for (int k = 0; k < 4 * L; k++) begin
            #1;
            if (gnt != 2'b00) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL rst_mid_gnt: got none want 01"); end
        @(negedge clk); req = 2'b00;
        repeat (6) @(negedge clk);
        #1; reset = 1'b0; req = 2'b11; #1;
        n_tests++;
        if ({gnt, busy, ser_in, done, done_id, dout} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_clear: got %h want 0", {gnt, busy, ser_in, done, done_id, dout});
        end
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk); #1;
            if (done || busy || gnt != 2'b00) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin n_fail++; $display("FAIL rst_mid_held: got activity want none"); end
        @(negedge clk); reset = 1'b1; model_last = 1;
        observe(1'b1, -1, 2'b00, ok, g, gc, sq, dc, dv, di, stray);
        n_tests++;
        if (!ok || g !== 2'b01 || dv !== w0 || di !== 1'b0 || stray) begin
            n_fail++; $display("FAIL rst_mid_first: got %b %h/%b stray=%0d want 01 %h/0", g, dv, di, stray, w0);
        end
        model_last = 0;
        observe(1'b1, -1, 2'b00, ok, g, gc, sq, dc, dv, di, stray);
        n_tests++;
        if (!ok || g !== 2'b10 || dv !== w1 || di !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_second: got %b %h/%b want 10 %h/1", g, dv, di, w1);
        end
        model_last = 1;
    endtask

    task automatic test_boundary();
        bit ok, stray; logic [1:0] g; int gc, dc, prev; logic [L-1:0] sq;
        logic [W-1:0] dv; logic di; logic [W-1:0] words [4];
        words = '{8'h00, 8'hFF, 8'h80, 8'h01}; prev = 0;
        for (int k = 0; k < 4; k++) begin
            din1 = words[k]; req = 2'b10;
            observe(1'b1, -1, 2'b00, ok, g, gc, sq, dc, dv, di, stray);
            n_tests++;
            if (!ok || g !== 2'b10 || dv !== words[k] || di !== 1'b1 || sq !== {words[k], 4'h0}) begin
                n_fail++;
                $display("FAIL boundary[%0d]: got %b %h/%b seq=%b want 10 %h/1", k, g, dv, di, sq, words[k]);
            end
            if (k > 0) begin
                n_tests++;
                if (gc - prev != L + 2) begin
                    n_fail++; $display("FAIL boundary_spacing[%0d]: got %0d want %0d", k, gc - prev, L + 2);
                end
            end
            prev = gc;
            model_last = 1;
        end
    endtask

    task automatic test_random();
        bit ok, stray; logic [1:0] g; int gc, dc, exp_id; logic [L-1:0] sq;
        logic [W-1:0] dv, exp_w; logic di;
        for (int k = 0; k < 24; k++) begin
            req  = req | 2'($urandom_range(1, 3));
            din0 = W'($urandom); din1 = W'($urandom);
            exp_id = pick(req);
            exp_w  = (exp_id == 1) ? din1 : din0;
            observe(1'b1, int'($urandom_range(0, L - 1)), 2'($urandom_range(0, 3)),
                    ok, g, gc, sq, dc, dv, di, stray);
            n_tests++;
            if (!ok || g !== ((exp_id == 1) ? 2'b10 : 2'b01) || stray || dc - gc != L + 1) begin
                n_fail++;
                $display("FAIL rand_gnt[%0d]: got %b lat=%0d stray=%0d want id %0d lat %0d",
                         k, g, dc - gc, stray, exp_id, L + 1);
            end
            n_tests++;
            if (dv !== exp_w || di !== 1'(exp_id) || sq !== {exp_w, 4'h0}) begin
                n_fail++; $display("FAIL rand_result[%0d]: got %h/%b want %h/%0d", k, dv, di, exp_w, exp_id);
            end
            model_last = exp_id;
        end
        req = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_param();
        bit ok, stray; int gc, dc; logic [1:0] g; logic [WS+DS-1:0] sq;
        din0_s = 4'h9; req_s = 2'b01; ok = 1'b0; stray = 1'b0; g = '0; gc = 0; sq = '0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (gnt_s != 2'b00) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        g = gnt_s; gc = cyc;
        n_tests++;
        if (!ok || g !== 2'b01) begin n_fail++; $display("FAIL param_gnt: got %b want 01", g); end
        @(negedge clk); req_s = 2'b00; #1;
        for (int c = 0; c < WS + DS; c++) begin
            sq[WS+DS-1-c] = ser_in_s;
            if (done_s) stray = 1'b1;
            @(negedge clk); #1;
        end
        ok = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (done_s) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
        dc = cyc;
        $display("[TB] xfer small gnt=%b at %0d done at %0d id=%0d dout=%h", g, gc, dc, done_id_s, dout_s);
        n_tests++;
        if (!ok || stray || dc - gc != WS + DS + 1) begin
            n_fail++; $display("FAIL param_latency: got %0d want %0d", dc - gc, WS + DS + 1);
        end
        n_tests++;
        if (dout_s !== 4'h9 || done_id_s !== 1'b0 || sq !== {4'h9, 1'b0}) begin
            n_fail++; $display("FAIL param_result: got %h/%b seq=%b want 9/0/10010", dout_s, done_id_s, sq);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_req_during_busy();
        test_reset_mid();
        test_boundary();
        test_random();
        test_param();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
